// File: rtl/setup_ctrl.sv
// Configuration-mode sequencer: walks bip enable, bip time, auto-lock time and
// password entry from the keypad buffer, then publishes them with a commit strobe.
module setup_ctrl #(
  parameter int UM_SEGUNDO = 1000,
  parameter int TIMEOUT_S  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        setup_on,
  input  logic [79:0] digitos_value,
  input  logic        digitos_valid,
  output logic        cfg_bip_on,
  output logic [5:0]  cfg_bip_time,
  output logic [5:0]  cfg_tranca_time,
  output logic [31:0] cfg_senha,
  output logic        data_setup_ok,
  output logic [2:0]  setup_step,
  output logic        setup_err
);

  localparam int LIMIT = TIMEOUT_S * UM_SEGUNDO;
  localparam int CW    = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

  localparam logic        RST_BIP_ON   = 1'b1;
  localparam logic [5:0]  RST_BIP_TIME = 6'd5;
  localparam logic [5:0]  RST_TRANCA   = 6'd10;
  localparam logic [31:0] RST_SENHA    = 32'h1234_5678;

  localparam logic [3:0] KEY_CONFIRM = 4'hA;
  localparam logic [3:0] KEY_SKIP    = 4'hB;
  localparam logic [3:0] KEY_EMPTY   = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_BIP_EN      = 3'd1,
    S_BIP_TIME    = 3'd2,
    S_TRANCA_TIME = 3'd3,
    S_SENHA       = 3'd4,
    S_COMMIT      = 3'd5
  } state_t;

  state_t       r_state, w_state_nxt, w_adv_state;
  logic         r_sh_bip_on, w_sh_bip_on_nxt;
  logic [5:0]   r_sh_bip_time, w_sh_bip_time_nxt;
  logic [5:0]   r_sh_tranca, w_sh_tranca_nxt;
  logic [31:0]  r_sh_senha, w_sh_senha_nxt;
  logic         r_cfg_bip_on;
  logic [5:0]   r_cfg_bip_time;
  logic [5:0]   r_cfg_tranca;
  logic [31:0]  r_cfg_senha;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic         r_err, w_err_nxt;
  logic         r_armed;

  logic [3:0]   w_nib0, w_nib1, w_nib2;
  logic         w_confirm, w_skip;
  logic [4:0]   w_k;
  logic         w_stop, w_bad;
  logic [6:0]   w_tens, w_time_val;
  logic         w_time_ok, w_entry_ok;
  logic         w_unused_nib19;

  assign w_nib0    = digitos_value[3:0];
  assign w_nib1    = digitos_value[7:4];
  assign w_nib2    = digitos_value[11:8];
  assign w_confirm = digitos_valid && (w_nib0 == KEY_CONFIRM);
  assign w_skip    = digitos_valid && (w_nib0 == KEY_SKIP);
  // Nibble 19 never belongs to a payload.
  assign w_unused_nib19 = ^digitos_value[79:76];

  // Payload length and digit check over nibbles 1..18, stopping at the first empty slot.
  // NOTE: combinational blocks use blocking '=' and give every output a default
  // first, so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    w_k    = 5'd0;
    w_stop = 1'b0;
    w_bad  = 1'b0;
    for (int i = 1; i < 19; i++) begin
      if (!w_stop) begin
        if (digitos_value[i*4 +: 4] == KEY_EMPTY) begin
          w_stop = 1'b1;
        end else begin
          w_k = w_k + 5'd1;
          if (digitos_value[i*4 +: 4] > 4'd9) w_bad = 1'b1;
        end
      end
    end
  end

  assign w_tens     = (w_k == 5'd2) ? 7'(w_nib2) * 7'd10 : 7'd0;
  assign w_time_val = w_tens + 7'(w_nib1);
  assign w_time_ok  = !w_bad && ((w_k == 5'd1) || (w_k == 5'd2)) &&
                      (w_time_val >= 7'd5) && (w_time_val <= 7'd60);

  always_comb begin
    w_entry_ok  = 1'b0;
    w_adv_state = S_IDLE;
    case (r_state)
      S_BIP_EN: begin
        w_entry_ok  = !w_bad && (w_k == 5'd1) && (w_nib1 <= 4'd1);
        w_adv_state = S_BIP_TIME;
      end
      S_BIP_TIME: begin
        w_entry_ok  = w_time_ok;
        w_adv_state = S_TRANCA_TIME;
      end
      S_TRANCA_TIME: begin
        w_entry_ok  = w_time_ok;
        w_adv_state = S_SENHA;
      end
      S_SENHA: begin
        w_entry_ok  = !w_bad && (w_k == 5'd8);
        w_adv_state = S_COMMIT;
      end
      default: ;
    endcase
  end

  // Next state, shadow updates, error strobe and inactivity counter.
  always_comb begin
    w_state_nxt       = r_state;
    w_sh_bip_on_nxt   = r_sh_bip_on;
    w_sh_bip_time_nxt = r_sh_bip_time;
    w_sh_tranca_nxt   = r_sh_tranca;
    w_sh_senha_nxt    = r_sh_senha;
    w_err_nxt         = 1'b0;
    w_cnt_nxt         = (r_cnt == LIMIT_C) ? r_cnt : r_cnt + CW'(1);
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (setup_on && r_armed) begin
          w_state_nxt       = S_BIP_EN;
          w_sh_bip_on_nxt   = r_cfg_bip_on;
          w_sh_bip_time_nxt = r_cfg_bip_time;
          w_sh_tranca_nxt   = r_cfg_tranca;
          w_sh_senha_nxt    = r_cfg_senha;
        end
      end
      S_BIP_EN, S_BIP_TIME, S_TRANCA_TIME, S_SENHA: begin
        if (!setup_on) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (digitos_valid) begin
          w_cnt_nxt = '0;
          if (w_skip) begin
            w_state_nxt = w_adv_state;
          end else if (w_confirm) begin
            if (w_entry_ok) begin
              w_state_nxt = w_adv_state;
              case (r_state)
                S_BIP_EN:      w_sh_bip_on_nxt   = w_nib1[0];
                S_BIP_TIME:    w_sh_bip_time_nxt = w_time_val[5:0];
                S_TRANCA_TIME: w_sh_tranca_nxt   = w_time_val[5:0];
                S_SENHA:       w_sh_senha_nxt    = digitos_value[35:4];
                default: ;
              endcase
            end else begin
              w_err_nxt = 1'b1;
            end
          end
        end else if (r_cnt == LIMIT_C) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      S_COMMIT: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values; reset is synchronous, so it is only tested inside the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_sh_bip_on    <= RST_BIP_ON;
      r_sh_bip_time  <= RST_BIP_TIME;
      r_sh_tranca    <= RST_TRANCA;
      r_sh_senha     <= RST_SENHA;
      r_cfg_bip_on   <= RST_BIP_ON;
      r_cfg_bip_time <= RST_BIP_TIME;
      r_cfg_tranca   <= RST_TRANCA;
      r_cfg_senha    <= RST_SENHA;
      r_cnt          <= '0;
      r_err          <= 1'b0;
      r_armed        <= 1'b1;
    end else begin
      r_state       <= w_state_nxt;
      r_sh_bip_on   <= w_sh_bip_on_nxt;
      r_sh_bip_time <= w_sh_bip_time_nxt;
      r_sh_tranca   <= w_sh_tranca_nxt;
      r_sh_senha    <= w_sh_senha_nxt;
      r_cnt         <= w_cnt_nxt;
      r_err         <= w_err_nxt;
      // Loaded on the edge into COMMIT so the new values coincide with data_setup_ok.
      if (w_state_nxt == S_COMMIT) begin
        r_cfg_bip_on   <= w_sh_bip_on_nxt;
        r_cfg_bip_time <= w_sh_bip_time_nxt;
        r_cfg_tranca   <= w_sh_tranca_nxt;
        r_cfg_senha    <= w_sh_senha_nxt;
      end
      if (!setup_on)                 r_armed <= 1'b1;
      else if (r_state == S_COMMIT)  r_armed <= 1'b0;
    end
  end

  assign cfg_bip_on      = r_cfg_bip_on;
  assign cfg_bip_time    = r_cfg_bip_time;
  assign cfg_tranca_time = r_cfg_tranca;
  assign cfg_senha       = r_cfg_senha;
  assign data_setup_ok   = (r_state == S_COMMIT);
  assign setup_step      = r_state;
  assign setup_err       = r_err;

endmodule

// File: tb/tb_setup_ctrl.sv
// Directed bench for setup_ctrl: full entry, range errors, skips, password
// length, abort, timeout boundaries and reset.
module tb_setup_ctrl;

  localparam int LIMIT = 10 * 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        setup_on;
  logic [79:0] digitos_value;
  logic        digitos_valid;
  logic        cfg_bip_on;
  logic [5:0]  cfg_bip_time;
  logic [5:0]  cfg_tranca_time;
  logic [31:0] cfg_senha;
  logic        data_setup_ok;
  logic [2:0]  setup_step;
  logic        setup_err;

  int n_checks = 0;
  int n_errors = 0;
  int ok_count = 0;
  int err_count = 0;

  setup_ctrl #(.UM_SEGUNDO(1000), .TIMEOUT_S(10)) dut (
    .clk             (clk),
    .rst             (rst),
    .setup_on        (setup_on),
    .digitos_value   (digitos_value),
    .digitos_valid   (digitos_valid),
    .cfg_bip_on      (cfg_bip_on),
    .cfg_bip_time    (cfg_bip_time),
    .cfg_tranca_time (cfg_tranca_time),
    .cfg_senha       (cfg_senha),
    .data_setup_ok   (data_setup_ok),
    .setup_step      (setup_step),
    .setup_err       (setup_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_setup_ok === 1'b1) ok_count++;
    if (setup_err === 1'b1) err_count++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_cfg(input string tag, input logic on, input logic [5:0] bt,
                           input logic [5:0] tt, input logic [31:0] pw);
    check({tag, ".bip_on"},    32'(cfg_bip_on),      32'(on));
    check({tag, ".bip_time"},  32'(cfg_bip_time),    32'(bt));
    check({tag, ".tranca"},    32'(cfg_tranca_time), 32'(tt));
    check({tag, ".senha"},     cfg_senha,            pw);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Buffer after typing n digits then 'key': digits[3:0] is the last typed digit.
  function automatic logic [79:0] kb(input logic [63:0] digits, input int n, input logic [3:0] key);
    logic [79:0] r;
    r = '1;
    r[3:0] = key;
    for (int i = 0; i < n; i++) r[(i+1)*4 +: 4] = digits[i*4 +: 4];
    return r;
  endfunction

  task automatic press(input logic [79:0] buf_v);
    digitos_value = buf_v;
    digitos_valid = 1'b1;
    tick();
    digitos_valid = 1'b0;
    digitos_value = '1;
  endtask

  task automatic rearm();
    setup_on = 1'b0;
    tick();
    setup_on = 1'b1;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; setup_on = 1'b0; digitos_valid = 1'b0; digitos_value = '1;
    tick(); tick();
    check("rst.step", 32'(setup_step), 32'd0);
    check("rst.ok",   32'(data_setup_ok), 32'd0);
    check("rst.err",  32'(setup_err), 32'd0);
    check_cfg("rst", 1'b1, 6'd5, 6'd10, 32'h12345678);
    rst = 1'b1;

    // Full valid entry.
    setup_on = 1'b1; tick();
    check("t1.step1", 32'(setup_step), 32'd1);
    press(kb(64'h1, 1, 4'hA));
    check("t1.step2", 32'(setup_step), 32'd2);
    press(kb(64'h07, 2, 4'hA));
    check("t1.step3", 32'(setup_step), 32'd3);
    press(kb(64'h3, 1, 4'h3));
    check("t1.digit_only", 32'(setup_step), 32'd3);
    press(kb(64'h15, 2, 4'hA));
    check("t1.step4", 32'(setup_step), 32'd4);
    press(kb(64'h87654321, 8, 4'hA));
    check("t1.commit_step", 32'(setup_step), 32'd5);
    check("t1.commit_ok", 32'(data_setup_ok), 32'd1);
    check_cfg("t1", 1'b1, 6'd7, 6'd15, 32'h87654321);
    tick();
    check("t1.idle", 32'(setup_step), 32'd0);
    check("t1.ok_low", 32'(data_setup_ok), 32'd0);
    tick();
    check("t1.no_reenter", 32'(setup_step), 32'd0);
    check("t1.ok_once", 32'(ok_count), 32'd1);
    check("t1.no_err", 32'(err_count), 32'd0);

    // Range errors in BIP_TIME.
    rearm();
    check("t2.step1", 32'(setup_step), 32'd1);
    press(kb(64'h0, 0, 4'hB));
    check("t2.step2", 32'(setup_step), 32'd2);
    press(kb(64'h3, 1, 4'hA));
    check("t2.err3", 32'(setup_err), 32'd1);
    check("t2.stay3", 32'(setup_step), 32'd2);
    tick();
    check("t2.err_pulse", 32'(setup_err), 32'd0);
    press(kb(64'h61, 2, 4'hA));
    check("t2.err61", 32'(setup_err), 32'd1);
    check("t2.stay61", 32'(setup_step), 32'd2);
    press(kb(64'h60, 2, 4'hA));
    check("t2.ok60", 32'(setup_err), 32'd0);
    check("t2.step3", 32'(setup_step), 32'd3);
    press(kb(64'h0, 0, 4'hA));
    check("t2.empty_err", 32'(setup_err), 32'd1);
    press(kb(64'h1C, 2, 4'hA));
    check("t2.nondigit_err", 32'(setup_err), 32'd1);
    check("t2.stay_tr", 32'(setup_step), 32'd3);
    press(kb(64'h0, 0, 4'hB));
    press(kb(64'h0, 0, 4'hB));
    check("t2.commit_ok", 32'(data_setup_ok), 32'd1);
    check_cfg("t2", 1'b1, 6'd60, 6'd15, 32'h87654321);
    tick();
    check("t2.err_total", 32'(err_count), 32'd4);

    // Skip every step.
    rearm();
    for (int i = 0; i < 4; i++) press(kb(64'h0, 0, 4'hB));
    check("t3.commit_ok", 32'(data_setup_ok), 32'd1);
    check_cfg("t3", 1'b1, 6'd60, 6'd15, 32'h87654321);
    tick();
    check("t3.ok_count", 32'(ok_count), 32'd3);

    // Password length.
    rearm();
    for (int i = 0; i < 3; i++) press(kb(64'h0, 0, 4'hB));
    check("t4.step4", 32'(setup_step), 32'd4);
    press(kb(64'h1234567, 7, 4'hA));
    check("t4.err7", 32'(setup_err), 32'd1);
    check("t4.stay4", 32'(setup_step), 32'd4);
    press(kb(64'h24681357, 8, 4'hA));
    check("t4.commit_ok", 32'(data_setup_ok), 32'd1);
    check_cfg("t4", 1'b1, 6'd60, 6'd15, 32'h24681357);
    tick();

    // Abort by dropping setup_on.
    rearm();
    press(kb(64'h0, 1, 4'hA));
    check("t5.step2", 32'(setup_step), 32'd2);
    setup_on = 1'b0; tick();
    check("t5.abort_idle", 32'(setup_step), 32'd0);
    check("t5.bip_on_kept", 32'(cfg_bip_on), 32'd1);
    check("t5.no_ok", 32'(ok_count), 32'd4);

    // Timeout: abort exactly after LIMIT idle cycles.
    setup_on = 1'b1; tick();
    check("t5.reenter", 32'(setup_step), 32'd1);
    repeat (LIMIT) tick();
    check("t5.before_to", 32'(setup_step), 32'd1);
    tick();
    check("t5.timeout", 32'(setup_step), 32'd0);
    rearm();
    press(kb(64'h0, 0, 4'h3));
    repeat (LIMIT - 1) tick();
    press(kb(64'h0, 0, 4'h4));
    check("t5.key_9999", 32'(setup_step), 32'd1);
    repeat (LIMIT) tick();
    press(kb(64'h0, 0, 4'h5));
    check("t5.key_wins", 32'(setup_step), 32'd1);
    setup_on = 1'b0;
    press(kb(64'h1, 1, 4'hA));
    check("t5.abort_wins", 32'(setup_step), 32'd0);
    check("t5.abort_no_err", 32'(setup_err), 32'd0);
    check("t5.ok_total", 32'(ok_count), 32'd4);

    // Reset in TRANCA_TIME with modified shadows.
    setup_on = 1'b1; tick();
    press(kb(64'h0, 1, 4'hA));
    press(kb(64'h33, 2, 4'hA));
    check("t6.step3", 32'(setup_step), 32'd3);
    rst = 1'b0; setup_on = 1'b0; tick(); rst = 1'b1;
    check("t6.step", 32'(setup_step), 32'd0);
    check("t6.ok", 32'(data_setup_ok), 32'd0);
    check("t6.err", 32'(setup_err), 32'd0);
    check_cfg("t6", 1'b1, 6'd5, 6'd10, 32'h12345678);
    setup_on = 1'b1; tick();
    for (int i = 0; i < 4; i++) press(kb(64'h0, 0, 4'hB));
    check("t6.commit_ok", 32'(data_setup_ok), 32'd1);
    check_cfg("t6c", 1'b1, 6'd5, 6'd10, 32'h12345678);
    tick();
    check("t6.ok_total", 32'(ok_count), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/setup_ctrl.md
# setup_ctrl

Configuration-mode sequencer for the lock controller. While `setup_on` is high it walks the user through four settings: bip enable, bip time, auto-lock time and 8-digit password. Each setting is read from the keypad digit buffer and validated. On completion it publishes the new configuration with a one-cycle `data_setup_ok` strobe. It sits between the keypad buffer and the `operacional` block and is the only writer of its setup inputs.

## Interface
- `UM_SEGUNDO`, 1000: clock cycles per second.
- `TIMEOUT_S`, 10: keypad inactivity timeout in seconds.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `setup_on`  in  1  configuration mode request from `operacional`, level.
- `digitos_value`  in  80  20-nibble keypad buffer.
  - Nibble 0 `[3:0]` is the newest key.
  - 0x0–0x9 are digits, 0xA is `*` (confirm), 0xB is `#` (skip), 0xF is empty.
- `digitos_valid`  in  1  one-cycle strobe; `digitos_value` is valid on this cycle.
- `cfg_bip_on`  out  1  committed bip enable.
- `cfg_bip_time`  out  6  committed bip time in seconds.
- `cfg_tranca_time`  out  6  committed auto-lock time in seconds.
- `cfg_senha`  out  32  committed password, 8 BCD nibbles, first-typed digit in `[31:28]`.
- `data_setup_ok`  out  1  one-cycle commit strobe.
- `setup_step`  out  3  current step, for the display.
- `setup_err`  out  1  one-cycle strobe on an invalid entry.

## Operation
- States and `setup_step` codes:
  - IDLE = 0
  - BIP_EN = 1
  - BIP_TIME = 2
  - TRANCA_TIME = 3
  - SENHA = 4
  - COMMIT = 5
- IDLE → BIP_EN on the first cycle `setup_on` is high. On this transition, shadow registers are loaded from the committed outputs.
- A key event is a cycle with `digitos_valid=1`. Events with nibble 0 equal to 0x0–0x9 only restart the timeout counter.
- Event with nibble 0 = 0xB (`#`): the shadow for the current step is kept unchanged and the FSM advances one step.
- Event with nibble 0 = 0xA (`*`): the payload is the run of nibbles starting at nibble 1 and ending before the first 0xF or nibble 19.
  - Let k be the payload length. Nibble 1 is the last digit typed.
  - Any payload nibble above 9 makes the entry invalid.
- Validity rules per step:
  - BIP_EN: k=1 and value 0 or 1.
  - BIP_TIME and TRANCA_TIME: k=1 or k=2; value = 10·nibble2 + nibble1 with nibble2 taken as 0 when k=1; value must be in 5..60.
  - SENHA: k=8. Nibble 8 maps to `cfg_senha[31:28]` and nibble 1 maps to `[3:0]`.
- Valid entry: the shadow is written and the FSM advances.
- Invalid entry: the shadow is unchanged, `setup_err` pulses, and the FSM stays in the same step.
- SENHA → COMMIT after a valid entry or a skip.
  - COMMIT copies all shadows to the `cfg_*` outputs and pulses `data_setup_ok`.
  - COMMIT then returns to IDLE. It does not re-enter BIP_EN until `setup_on` has been low for at least one cycle.
- Abort returns to IDLE, discards the shadows, and produces no `data_setup_ok`. Abort is triggered by either:
  - `setup_on` going low in any non-IDLE state other than COMMIT;
  - timeout: the inactivity counter reaching `TIMEOUT_S·UM_SEGUNDO` cycles.
- Inactivity counter:
  - cleared on every key event and in IDLE;
  - saturating;
  - width of at least clog2(`TIMEOUT_S·UM_SEGUNDO`+1).
- Key events in IDLE are ignored.

## Timing
- Reset (`rst=0` at a clock edge), regardless of state, sets:
  - state IDLE, `setup_step`=0, `data_setup_ok`=0, `setup_err`=0;
  - `cfg_bip_on`=1, `cfg_bip_time`=5, `cfg_tranca_time`=10, `cfg_senha`=32'h12345678;
  - shadows equal to the cfg reset values, timeout counter 0.
- Key event on edge N: `setup_step` and `setup_err` reflect the result after edge N, a latency of 1 cycle.
- `setup_err` is high for exactly 1 cycle.
- COMMIT is held for exactly 1 cycle. `data_setup_ok` is high during it, and the `cfg_*` outputs show the new values on the same cycle as `data_setup_ok`. After that cycle `setup_step` is 0.
- `cfg_*` outputs change only in COMMIT or on reset, never during abort.
- `setup_on` low together with a key event in the same cycle: the abort wins and the event is ignored.
- Timeout expiry together with a key event in the same cycle: the key event wins and the counter is cleared.
- `digitos_value` is sampled only when `digitos_valid` is high.

## Test plan
- Reset, then `setup_on`=1. Enter `1*`, `07*`, `15*`, `87654321*`.
  - Expected: `setup_step` goes 1→2→3→4. `data_setup_ok` pulses once with bip_on=1, bip_time=7, tranca_time=15, senha=32'h87654321. `setup_step` is then 0.
- In BIP_TIME, enter `3*`, then `61*`, then `60*`.
  - Expected: two `setup_err` pulses and step stays 2, then step 3. The final commit has bip_time=60.
- Press `#` at all four steps.
  - Expected: `data_setup_ok` pulses and every `cfg_*` value equals the previous committed value.
- In SENHA, enter 7 digits then `*`.
  - Expected: `setup_err` pulses and step stays 4. Then enter 8 digits then `*`: commit occurs.
- Enter `0*` in BIP_EN, then drop `setup_on` in BIP_TIME.
  - Expected: back to IDLE with no `data_setup_ok`, and `cfg_bip_on` stays 1.
  - Raise `setup_on` again, then give no keys for 10·1000 cycles: abort to step 0.
  - With no keys for 9999 cycles followed by a key, the FSM is still in its step.
- Drive `rst=0` for one cycle while in TRANCA_TIME with a modified shadow.
  - Expected: all outputs return to their reset values and `data_setup_ok` is never asserted.
